alarm_ctrl: RTL and testbench

Alarm controller that sits directly downstream of the time-of-day counter and consumes its BCD digit outputs (H1, H2, M1, M2, S1, S2). It compares the running time against a stored alarm time and runs the ring/snooze/timeout state machine. It drives a ringing flag and a 1 Hz pulsed buzzer output toward the LED/buzzer and display stages.

---
 rtl/alarm_ctrl.sv | 135 +++++++++++++
 tb/tb_alarm_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares the BCD time-of-day against the stored alarm time
// and runs the ring / snooze / timeout state machine that drives the buzzer.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic [2:0] S1,
  input  logic [3:0] S2,
  input  logic [1:0] AH1,
  input  logic [3:0] AH2,
  input  logic [2:0] AM1,
  input  logic [3:0] AM2,
  input  logic       alarm_en,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [1:0] state,
  output logic       ringing,
  output logic       buzz,
  output logic [1:0] snoozes_left
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
  localparam logic [1:0]       LEFT_FULL   = 2'(MAX_SNOOZE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             beep_q, beep_d;
  logic             ring_q, ring_d;
  logic [1:0]       left_q, left_d;
  logic             match_q;
  logic             match, match_rise, cancel;

  assign match = alarm_en & (H1 == AH1) & (H2 == AH2) & (M1 == AM1) & (M2 == AM2)
               & (S1 == 3'd0) & (S2 == 4'd0);
  assign match_rise = match & ~match_q;
  assign cancel     = btn_stop | ~alarm_en;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beep_d  = beep_q;
    left_d  = left_q;
    unique case (state_q)
      ST_IDLE: begin
        beep_d = 1'b0;
        if (match_rise) begin
          state_d = ST_RING;
          timer_d = RING_LOAD;
          beep_d  = 1'b1;
        end
      end
      ST_RING: begin
        if (cancel) begin
          state_d = ST_IDLE;
          beep_d  = 1'b0;
        end else if (btn_snooze && left_q != 2'd0) begin
          state_d = ST_SNOOZE;
          timer_d = SNOOZE_LOAD;
          left_d  = left_q - 2'd1;
          beep_d  = 1'b0;
        end else if (sec_tick) begin
          // A snooze press with no snoozes left falls through, so the tick still counts.
          if (timer_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            beep_d  = 1'b0;
          end else begin
            timer_d = timer_q - CNT_W'(1);
            beep_d  = ~beep_q;
          end
        end
      end
      ST_SNOOZE: begin
        beep_d = 1'b0;
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (sec_tick) begin
          if (timer_q == CNT_W'(1)) begin
            state_d = ST_RING;
            timer_d = RING_LOAD;
            beep_d  = 1'b1;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beep_d  = 1'b0;
      end
    endcase
    // Snooze budget refills the moment the event ends, not a cycle later.
    if (state_d == ST_IDLE) left_d = LEFT_FULL;
    ring_d = (state_d == ST_RING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      beep_q  <= 1'b0;
      ring_q  <= 1'b0;
      left_q  <= LEFT_FULL;
      match_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beep_q  <= beep_d;
      ring_q  <= ring_d;
      left_q  <= left_d;
      match_q <= match;
    end
  end

  assign state        = state_q;
  assign ringing      = ring_q;
  assign buzz         = ring_q & beep_q;
  assign snoozes_left = left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short ring/snooze durations and alarm 07:30.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick, alarm_en, btn_stop, btn_snooze;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic [2:0] S1;
  logic [3:0] S2;
  logic [1:0] state;
  logic       ringing, buzz;
  logic [1:0] snoozes_left;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_ctrl #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(3), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .AH1(2'd0), .AH2(4'd7), .AM1(3'd3), .AM2(4'd0),
    .alarm_en(alarm_en), .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .state(state), .ringing(ringing), .buzz(buzz), .snoozes_left(snoozes_left)
  );

  always #5 clk = ~clk;

  // tm: 0 = 07:29:59, 1 = 07:30:00, 2 = 07:30:01
  typedef struct {
    logic [1:0] tm;
    logic       tick, stop, snz, en;
    logic [1:0] e_state;
    logic       e_ring, e_buzz;
    logic [1:0] e_left;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] tm, input logic tick, input logic stop,
                     input logic snz, input logic en, input logic [1:0] es,
                     input logic er, input logic eb, input logic [1:0] el);
    vec_t v;
    v.tm = tm; v.tick = tick; v.stop = stop; v.snz = snz; v.en = en;
    v.e_state = es; v.e_ring = er; v.e_buzz = eb; v.e_left = el;
    vq.push_back(v);
  endtask

  task automatic set_time(input logic [1:0] tm);
    H1 = 2'd0; H2 = 4'd7;
    case (tm)
      2'd0:    begin M1 = 3'd2; M2 = 4'd9; S1 = 3'd5; S2 = 4'd9; end
      2'd1:    begin M1 = 3'd3; M2 = 4'd0; S1 = 3'd0; S2 = 4'd0; end
      default: begin M1 = 3'd3; M2 = 4'd0; S1 = 3'd0; S2 = 4'd1; end
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] es, input logic er,
                            input logic eb, input logic [1:0] el);
    check({tag, ".state"},   8'(state),        8'(es));
    check({tag, ".ringing"}, 8'(ringing),      8'(er));
    check({tag, ".buzz"},    8'(buzz),         8'(eb));
    check({tag, ".left"},    8'(snoozes_left), 8'(el));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    set_time(v.tm);
    sec_tick = v.tick; btn_stop = v.stop; btn_snooze = v.snz; alarm_en = v.en;
    @(posedge clk);
    #1;
    check_outs(tag, v.e_state, v.e_ring, v.e_buzz, v.e_left);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sec_tick = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0;
      @(posedge clk);
      #1;
      check_outs($sformatf("%s%0d", tag, k), 2'b00, 1'b0, 1'b0, 2'd3);
    end
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0; alarm_en = 1'b1;
    set_time(2'd0);
    #1;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 2'd3);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    //   tm  tk st sz en   state ring buzz left
    // Plain ring and timeout: buzz 1,0,1,0 then idle
    add(0, 0, 0, 0, 1, 2'b00, 0, 0, 3);
    add(1, 0, 0, 0, 1, 2'b01, 1, 1, 3);
    add(1, 0, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 0, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 0, 3);
    add(2, 1, 0, 0, 1, 2'b00, 0, 0, 3);
    // Three snoozes, each re-ringing after 3 ticks
    add(0, 0, 0, 0, 1, 2'b00, 0, 0, 3);
    add(1, 0, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 0, 0, 1, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 2);
    add(2, 0, 0, 1, 1, 2'b10, 0, 0, 1);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 1);
    add(2, 0, 0, 1, 1, 2'b10, 0, 0, 1);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 1);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 1);
    add(2, 0, 0, 1, 1, 2'b10, 0, 0, 0);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 0);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 0);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 0);
    // Fourth snooze ignored, then stop refills the budget
    add(2, 0, 0, 1, 1, 2'b01, 1, 1, 0);
    add(2, 0, 1, 0, 1, 2'b00, 0, 0, 3);
    // Stop coincident with the final tick
    add(0, 0, 0, 0, 1, 2'b00, 0, 0, 3);
    add(1, 0, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 0, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 1, 0, 0, 1, 2'b01, 1, 0, 3);
    add(2, 1, 1, 0, 1, 2'b00, 0, 0, 3);
    // Snooze coincident with a tick: snooze wins, tick not counted
    add(0, 0, 0, 0, 1, 2'b00, 0, 0, 3);
    add(1, 0, 0, 0, 1, 2'b01, 1, 1, 3);
    add(2, 1, 0, 1, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b10, 0, 0, 2);
    add(2, 1, 0, 0, 1, 2'b01, 1, 1, 2);
    add(2, 1, 0, 0, 1, 2'b01, 1, 0, 2);
    // alarm_en dropped during snooze
    add(2, 0, 0, 1, 1, 2'b10, 0, 0, 1);
    add(2, 0, 0, 0, 0, 2'b00, 0, 0, 3);
    add(2, 0, 0, 0, 1, 2'b00, 0, 0, 3);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

    // Reset released while the time already equals the alarm time: no ring
    @(negedge clk);
    set_time(2'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    idle_cycles(3, "noring");

    // Asynchronous reset mid-ring clears outputs before the next clock edge
    @(negedge clk) set_time(2'd0);
    @(negedge clk) set_time(2'd1);
    @(posedge clk);
    #1;
    check_outs("prering", 2'b01, 1'b1, 1'b1, 2'd3);
    #1 rst = 1'b1;
    #1;
    check_outs("asyncrst", 2'b00, 1'b0, 1'b0, 2'd3);
    @(negedge clk) rst = 1'b0;
    idle_cycles(2, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
